// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture controller.
// Holds the FSM state encoding, error codes and the starting row-base helper.
package frame_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE,
    ERR
  } cap_state_e;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_SHORT_FRAME = 2'b01;
  localparam logic [1:0] ERR_SHORT_LINE  = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW    = 2'b11;

  // Word address of the first captured line: last RAM row for BMP order.
  function automatic int unsigned row_base_init(input int unsigned hdisp,
                                                input int unsigned vdisp,
                                                input bit          bottom_up);
    return bottom_up ? (vdisp - 1) * hdisp : 0;
  endfunction

endpackage

// File: rtl/video_geom_counter.sv
// Video geometry tracker: vsync/de edge detection, column/line counters and an
// incrementally stepped row base so the RAM address needs no multiplier.
module video_geom_counter
  import frame_capture_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int BOTTOM_UP = 1,
  parameter int AW        = $clog2(IMG_HDISP * IMG_VDISP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          video_vsync,
  input  logic          video_de,
  input  logic          clear,
  input  logic          run,
  output logic          fs,
  output logic          overflow,
  output logic          short_line,
  output logic          final_px,
  output logic [AW-1:0] addr
);

  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int LW = $clog2(IMG_VDISP + 1);
  localparam logic [CW-1:0] H_FULL   = CW'(IMG_HDISP);
  localparam logic [CW-1:0] H_LAST   = CW'(IMG_HDISP - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(IMG_VDISP - 1);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_HDISP);
  localparam logic [AW-1:0] ROW_INIT =
    AW'(row_base_init(int'(IMG_HDISP), int'(IMG_VDISP), BOTTOM_UP != 0));

  logic          vsync_d1;
  logic          de_d1;
  logic          de_fall;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [AW-1:0] row_base;

  assign fs         = vsync_d1 & ~video_vsync;
  assign de_fall    = de_d1 & ~video_de;
  assign overflow   = video_de && (col == H_FULL);
  assign short_line = de_fall && (col != H_FULL);
  assign final_px   = video_de && (line == L_LAST) && (col == H_LAST);
  assign addr       = row_base + AW'(col);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d1 <= 1'b0;
      de_d1    <= 1'b0;
      col      <= '0;
      line     <= '0;
      row_base <= '0;
    end else begin
      vsync_d1 <= video_vsync;
      de_d1    <= video_de;
      if (clear) begin
        col      <= '0;
        line     <= '0;
        row_base <= ROW_INIT;
      end else if (run) begin
        if (video_de && (col != H_FULL)) begin
          col <= col + 1'b1;
        end else if (de_fall && (col == H_FULL)) begin
          col      <= '0;
          line     <= line + 1'b1;
          row_base <= (BOTTOM_UP != 0) ? row_base - ROW_STEP : row_base + ROW_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Single-frame capture controller: arms on cap_start, skips N frame starts,
// then writes each active pixel of one frame to RAM and checks its geometry.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int IMG_HDISP  = 640,
  parameter int IMG_VDISP  = 480,
  parameter int DATA_WIDTH = 24,
  parameter int BOTTOM_UP  = 1,
  parameter int AW         = $clog2(IMG_HDISP * IMG_VDISP)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  video_vsync,
  input  logic                  video_hsync,
  input  logic                  video_de,
  input  logic [DATA_WIDTH-1:0] video_data,
  input  logic                  cap_start,
  input  logic [2:0]            cap_skip,
  input  logic                  cap_abort,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic                  cap_err,
  output logic [1:0]            err_code,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  cap_state_e    state, next_state;
  logic [2:0]    skip_cnt;
  logic          fs, overflow, short_line, final_px;
  logic [AW-1:0] pix_addr;
  logic          start_ok, arm_hit, set_err, write_ok;
  logic [1:0]    err_next;
  logic          unused_hsync;

  assign unused_hsync = video_hsync;

  video_geom_counter #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .BOTTOM_UP (BOTTOM_UP),
    .AW        (AW)
  ) u_geom (
    .clk         (clk),
    .rst_n       (rst_n),
    .video_vsync (video_vsync),
    .video_de    (video_de),
    .clear       (arm_hit),
    .run         (state == CAPTURE),
    .fs          (fs),
    .overflow    (overflow),
    .short_line  (short_line),
    .final_px    (final_px),
    .addr        (pix_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Completion beats geometry errors, which beat a premature frame start.
  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    arm_hit    = 1'b0;
    set_err    = 1'b0;
    err_next   = ERR_NONE;
    case (state)
      IDLE: if (cap_start) begin
        next_state = ARMED;
        start_ok   = 1'b1;
      end
      ARMED: if (fs && (skip_cnt == 3'd0)) begin
        next_state = CAPTURE;
        arm_hit    = 1'b1;
      end
      CAPTURE: begin
        if (final_px) begin
          next_state = DONE;
        end else if (overflow) begin
          next_state = ERR;
          set_err    = 1'b1;
          err_next   = ERR_OVERFLOW;
        end else if (short_line) begin
          next_state = ERR;
          set_err    = 1'b1;
          err_next   = ERR_SHORT_LINE;
        end else if (fs) begin
          next_state = ERR;
          set_err    = 1'b1;
          err_next   = ERR_SHORT_FRAME;
        end
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (cap_abort) begin
      next_state = IDLE;
      start_ok   = 1'b0;
      arm_hit    = 1'b0;
      set_err    = 1'b0;
    end
  end

  always_comb begin
    cap_busy = (state == ARMED) || (state == CAPTURE);
    cap_done = (state == DONE);
    cap_err  = (state == ERR);
  end

  assign write_ok = (state == CAPTURE) && video_de && !overflow && !cap_abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skip_cnt <= '0;
      err_code <= ERR_NONE;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (start_ok)
        skip_cnt <= cap_skip;
      else if ((state == ARMED) && fs && (skip_cnt != 3'd0) && !cap_abort)
        skip_cnt <= skip_cnt - 1'b1;
      if (start_ok)     err_code <= ERR_NONE;
      else if (set_err) err_code <= err_next;
      wr_en <= write_ok;
      if (write_ok) begin
        wr_addr <= pix_addr;
        wr_data <= video_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on an 8x4 frame, bottom-up addressing.
module tb_frame_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          video_vsync, video_hsync, video_de;
  logic [DW-1:0] video_data;
  logic          cap_start, cap_abort;
  logic [2:0]    cap_skip;
  logic          cap_busy, cap_done, cap_err;
  logic [1:0]    err_code;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int tests = 0;
  int fails = 0;

  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, done_wr_cnt = 0;
  logic [DW-1:0] mem [0:H*V-1];

  frame_capture_ctrl #(
    .IMG_HDISP  (H),
    .IMG_VDISP  (V),
    .DATA_WIDTH (DW),
    .BOTTOM_UP  (1),
    .AW         (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .video_vsync (video_vsync),
    .video_hsync (video_hsync),
    .video_de    (video_de),
    .video_data  (video_data),
    .cap_start   (cap_start),
    .cap_skip    (cap_skip),
    .cap_abort   (cap_abort),
    .cap_busy    (cap_busy),
    .cap_done    (cap_done),
    .cap_err     (cap_err),
    .err_code    (err_code),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  always #5 clk = ~clk;

  // RAM model and event counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      mem[wr_addr] = wr_data;
    end
    if (cap_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (wr_en === 1'b1) done_wr_cnt = done_wr_cnt + 1;
    end
    if (cap_err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    video_de = 1'b0;
    video_data = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic vsync_pulse;
    video_vsync = 1'b1;
    tick();
    tick();
    video_vsync = 1'b0;
    tick();
  endtask

  task automatic drive_line(input int len, input int d0, input bit ramp);
    for (int i = 0; i < len; i++) begin
      video_de = 1'b1;
      video_data = ramp ? DW'(d0 + i) : DW'(d0);
      tick();
    end
    video_de = 1'b0;
    video_data = '0;
  endtask

  task automatic arm(input int skip);
    cap_skip = 3'(skip);
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    cap_skip = 3'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    video_vsync = 1'b0; video_hsync = 1'b0; video_de = 1'b0; video_data = '0;
    cap_start = 1'b0; cap_skip = 3'd0; cap_abort = 1'b0;
    tick(); tick();
    tests++; if ({cap_busy, cap_done, cap_err} !== 3'b000) begin fails++;
      $display("FAIL reset_status: got %b expected 000", {cap_busy, cap_done, cap_err}); end
    tests++; if (err_code !== 2'b00) begin fails++;
      $display("FAIL reset_err_code: got %0d expected 0", err_code); end
    tests++; if ({wr_en, wr_addr, wr_data} !== '0) begin fails++;
      $display("FAIL reset_wr: got en=%b addr=%0d data=%0h expected zeros", wr_en, wr_addr, wr_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal;
    int w0, d0, dw0, e0, bad;
    gap(3);
    w0 = wr_cnt; d0 = done_cnt; dw0 = done_wr_cnt; e0 = err_cnt;
    arm(0);
    tests++; if (cap_busy !== 1'b1) begin fails++;
      $display("FAIL normal_busy_armed: got %b expected 1", cap_busy); end
    vsync_pulse();
    for (int l = 0; l < V; l++) begin
      drive_line(H, l * H, 1'b1);
      gap(2);
    end
    tests++; if (wr_cnt - w0 !== 32) begin fails++;
      $display("FAIL normal_writes: got %0d expected 32", wr_cnt - w0); end
    for (int c = 0; c < H; c++) begin
      tests++; if (mem[24 + c] !== DW'(c)) begin fails++;
        $display("FAIL normal_first_line[%0d]: got %0d expected %0d", c, mem[24 + c], c); end
      tests++; if (mem[c] !== DW'(24 + c)) begin fails++;
        $display("FAIL normal_last_line[%0d]: got %0d expected %0d", c, mem[c], 24 + c); end
    end
    bad = 0;
    for (int l = 0; l < V; l++)
      for (int c = 0; c < H; c++)
        if (mem[(V - 1 - l) * H + c] !== DW'(l * H + c)) bad++;
    tests++; if (bad !== 0) begin fails++;
      $display("FAIL normal_ram_image: got %0d bad words expected 0", bad); end
    tests++; if (done_cnt - d0 !== 1) begin fails++;
      $display("FAIL normal_done_count: got %0d expected 1", done_cnt - d0); end
    tests++; if (done_wr_cnt - dw0 !== 1) begin fails++;
      $display("FAIL normal_done_with_last_write: got %0d expected 1", done_wr_cnt - dw0); end
    tests++; if (err_cnt - e0 !== 0 || err_code !== 2'b00) begin fails++;
      $display("FAIL normal_no_error: got errs=%0d code=%0d expected 0/0", err_cnt - e0, err_code); end
    tests++; if (cap_busy !== 1'b0) begin fails++;
      $display("FAIL normal_idle_after: got busy=%b expected 0", cap_busy); end
  endtask

  task automatic test_skip;
    int w0, bad;
    int per_frame [4];
    int expw [4];
    expw = '{0, 0, 32, 0};
    gap(3);
    arm(2);
    for (int k = 0; k < 4; k++) begin
      w0 = wr_cnt;
      vsync_pulse();
      for (int l = 0; l < V; l++) begin
        drive_line(H, k, 1'b0);
        gap(2);
      end
      per_frame[k] = wr_cnt - w0;
    end
    for (int k = 0; k < 4; k++) begin
      tests++; if (per_frame[k] !== expw[k]) begin fails++;
        $display("FAIL skip_frame%0d_writes: got %0d expected %0d", k, per_frame[k], expw[k]); end
    end
    bad = 0;
    for (int a = 0; a < H * V; a++) if (mem[a] !== DW'(2)) bad++;
    tests++; if (bad !== 0) begin fails++;
      $display("FAIL skip_data_is_frame2: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_short_line;
    int w0;
    gap(3);
    arm(0);
    w0 = wr_cnt;
    vsync_pulse();
    drive_line(H, 0, 1'b1); gap(2);
    drive_line(H, 8, 1'b1); gap(2);
    drive_line(7, 16, 1'b1);
    tick();
    tests++; if (cap_err !== 1'b1 || err_code !== 2'b10) begin fails++;
      $display("FAIL short_line_err: got err=%b code=%0d expected 1/2", cap_err, err_code); end
    tests++; if (cap_busy !== 1'b0) begin fails++;
      $display("FAIL short_line_busy: got %b expected 0", cap_busy); end
    gap(2);
    tests++; if (wr_cnt - w0 !== 23) begin fails++;
      $display("FAIL short_line_writes: got %0d expected 23", wr_cnt - w0); end
  endtask

  task automatic test_overflow;
    int w0;
    gap(3);
    arm(0);
    w0 = wr_cnt;
    vsync_pulse();
    drive_line(H, 0, 1'b1); gap(2);
    drive_line(9, 8, 1'b1);
    tests++; if (cap_err !== 1'b1 || err_code !== 2'b11) begin fails++;
      $display("FAIL overflow_err: got err=%b code=%0d expected 1/3", cap_err, err_code); end
    tests++; if (wr_en !== 1'b0) begin fails++;
      $display("FAIL overflow_no_ninth_write: got wr_en=%b expected 0", wr_en); end
    gap(2);
    tests++; if (wr_cnt - w0 !== 16) begin fails++;
      $display("FAIL overflow_writes: got %0d expected 16", wr_cnt - w0); end
  endtask

  task automatic test_short_frame;
    int w0;
    gap(3);
    arm(0);
    w0 = wr_cnt;
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      drive_line(H, l * H, 1'b1);
      gap(2);
    end
    vsync_pulse();
    tests++; if (cap_err !== 1'b1 || err_code !== 2'b01) begin fails++;
      $display("FAIL short_frame_err: got err=%b code=%0d expected 1/1", cap_err, err_code); end
    tests++; if (wr_cnt - w0 !== 24) begin fails++;
      $display("FAIL short_frame_writes: got %0d expected 24", wr_cnt - w0); end
  endtask

  task automatic test_abort;
    int w0, d0, e0;
    gap(3);
    arm(0);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    vsync_pulse();
    drive_line(H, 0, 1'b1); gap(2);
    drive_line(3, 8, 1'b1);
    video_de = 1'b1; video_data = DW'(11); cap_abort = 1'b1;
    tick();
    cap_abort = 1'b0;
    tests++; if (cap_busy !== 1'b0 || wr_en !== 1'b0) begin fails++;
      $display("FAIL abort_idle: got busy=%b wr_en=%b expected 0/0", cap_busy, wr_en); end
    drive_line(4, 12, 1'b1);
    gap(3);
    tests++; if (wr_cnt - w0 !== 11) begin fails++;
      $display("FAIL abort_writes: got %0d expected 11", wr_cnt - w0); end
    tests++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin fails++;
      $display("FAIL abort_no_pulse: got done=%0d err=%0d expected 0/0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    gap(3);
    arm(0);
    vsync_pulse();
    drive_line(H, 0, 1'b1); gap(2);
    for (int i = 0; i < 4; i++) begin
      video_de = 1'b1; video_data = DW'(40 + i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    tests++; if ({cap_busy, cap_done, cap_err, err_code} !== 5'b0) begin fails++;
      $display("FAIL reset_mid_status: got busy=%b done=%b err=%b code=%0d expected zeros",
               cap_busy, cap_done, cap_err, err_code); end
    tests++; if ({wr_en, wr_addr, wr_data} !== '0) begin fails++;
      $display("FAIL reset_mid_wr: got en=%b addr=%0d data=%0h expected zeros", wr_en, wr_addr, wr_data); end
    rst_n = 1'b1;
    gap(2);
  endtask

  task automatic test_start_busy;
    int w0, d0, e0;
    gap(3);
    arm(0);
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    vsync_pulse();
    drive_line(H, 5, 1'b0);
    cap_start = 1'b1; cap_skip = 3'd3;
    tick();
    cap_start = 1'b0; cap_skip = 3'd0;
    tests++; if (cap_busy !== 1'b1) begin fails++;
      $display("FAIL start_busy_still_busy: got %b expected 1", cap_busy); end
    tick();
    for (int l = 1; l < V; l++) begin
      drive_line(H, 5, 1'b0);
      gap(2);
    end
    tests++; if (wr_cnt - w0 !== 32 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin fails++;
      $display("FAIL start_busy_completes: got wr=%0d done=%0d err=%0d expected 32/1/0",
               wr_cnt - w0, done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_skip();
    test_short_line();
    test_overflow();
    test_short_frame();
    test_abort();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Synthesizable controller that selects one frame from the 24-bit video stream and sequences its pixels into an external frame-buffer RAM, one write per active pixel. It sits between the video source (vsync/hsync/de/data) and a single-port capture RAM, and is armed and monitored by a host or testbench through a start/done/abort handshake. It checks frame geometry (line length, line count, early frame end) and reports errors. It can emit addresses in BMP bottom-up row order so the RAM contents dump directly as a BMP pixel array.

## Interface
- IMG_HDISP, 640, active pixels per line
- IMG_VDISP, 480, active lines per frame
- DATA_WIDTH, 24, pixel width, {R[23:16],G[15:8],B[7:0]}
- BOTTOM_UP, 1, 1: last line maps to address 0 (BMP order); 0: top-down raster
- AW, $clog2(IMG_HDISP*IMG_VDISP), write address width
- clk  in  1  single clock for all logic
- rst_n  in  1  synchronous, active-low reset
- video_vsync  in  1  active high; its falling edge marks frame start
- video_hsync  in  1  not used for control; ignored
- video_de  in  1  active-pixel qualifier
- video_data  in  DATA_WIDTH  pixel
- cap_start  in  1  one-cycle arm request, honoured only in IDLE
- cap_skip  in  3  frame starts to skip before capture, sampled with cap_start
- cap_abort  in  1  cancel; highest priority
- cap_busy  out  1  high in ARMED or CAPTURE
- cap_done  out  1  one-cycle pulse on a successful capture
- cap_err  out  1  one-cycle pulse on a geometry error
- err_code  out  2  00 none, 01 short frame, 10 short line, 11 line overflow; held until the next accepted cap_start
- wr_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM word address
- wr_data  out  DATA_WIDTH  RAM write data

## Operation
- Frame-start edge: fs = vsync_d1 & ~video_vsync. vsync_d1 is a register with reset value 0.
- States: IDLE, ARMED, CAPTURE, DONE, ERR.
- IDLE, cap_start=1: latch skip_cnt=cap_skip, clear err_code, go to ARMED.
  - An fs in the same cycle as cap_start is not counted.
- ARMED, on each fs:
  - skip_cnt==0: go to CAPTURE and clear col/line.
  - otherwise: decrement skip_cnt.
  - cap_skip=0 captures the next frame to start.
- CAPTURE, each de=1 cycle:
  - Write the pixel and increment col.
  - If col==IMG_HDISP already: line overflow, err_code=11, go to ERR, no write.
- CAPTURE, de falling edge (de_d1 & ~de):
  - col!=IMG_HDISP: short line, err_code=10, go to ERR.
  - otherwise: line++ and col=0.
- CAPTURE, final pixel (line==IMG_VDISP-1 and col==IMG_HDISP-1 with de=1): write it and go to DONE. Trailing de-low cycles are not checked.
- CAPTURE, fs before the final pixel: short frame, err_code=01, go to ERR.
- DONE: assert cap_done, then IDLE. ERR: assert cap_err, then IDLE.
- Address:
  - BOTTOM_UP=1: wr_addr = (IMG_VDISP-1-line)*IMG_HDISP + col.
  - BOTTOM_UP=0: wr_addr = line*IMG_HDISP + col.
  - Computed incrementally with a row-base register (add or subtract IMG_HDISP per line); no multiplier.
- cap_abort=1 in any state: next state is IDLE. No done/err pulse; wr_en=0 in that cycle; err_code unchanged.
- Simultaneous events:
  - Final pixel together with fs: completion wins, go to DONE.
  - Overflow or short line together with fs: the geometry error code wins.
  - cap_start outside IDLE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; err_code 00; counters 0.
- Latency: pixel sampled at cycle N gives wr_en/wr_addr/wr_data registered at N+1.
- Final pixel sampled at N: cap_done=1 at N+1, the same cycle as the last wr_en. cap_busy=0 from N+1.
- Error detected at N: cap_err=1 and err_code valid at N+1, cap_busy=0 at N+1.
- De on the fs cycle while ARMED is not captured; capture starts at the cycle after fs.
- Reset mid-capture: everything returns to reset values on the next clk edge. Partial RAM contents are not cleared.

## Structure
- Package frame_capture_pkg holds:
  - the state enum (cap_state_e);
  - the error-code constants (ERR_NONE, ERR_SHORT_FRAME, ERR_SHORT_LINE, ERR_OVERFLOW).
- Sub-module video_geom_counter: de/vsync edge detect, col/line counters, row-base address, overflow/short-line/final-pixel flags.
- The FSM and handshake stay in frame_capture_ctrl.

## Test plan
Use IMG_HDISP=8, IMG_VDISP=4 for all scenarios.
- Normal capture, BOTTOM_UP=1, cap_skip=0, ramp pixels 0..31:
  - exactly 32 wr_en pulses;
  - first line goes to addr 24..31, last line to addr 0..7;
  - cap_done pulses once, the same cycle as the last write;
  - err_code=00.
- cap_skip=2 with 4 frames, frame k data = k:
  - writes occur only during frame 2, all wr_data=2;
  - frames 0, 1 and 3 produce no wr_en.
- Line 2 of 7 pixels:
  - cap_err at the de fall, err_code=10, cap_busy=0;
  - 16+7 writes issued.
- Line 1 of 9 pixels:
  - no 9th write, cap_err, err_code=11.
- Short frame and abort:
  - 3-line frame followed by fs: err_code=01.
  - Separately, cap_abort mid-line 1: IDLE next cycle, no done/err, wr_en=0 from then on.
- Reset and start corner cases:
  - rst_n low mid-capture: all outputs 0 next cycle.
  - cap_start during CAPTURE: ignored, capture continues to cap_done.
